// File: rtl/k2_program_loader.sv
// Writable instruction store and load/run sequencer for the K2 processor.
// Optional feature: define CHECKSUM_EN to require a trailing checksum beat per load.
module k2_program_loader #(
    parameter int ADDR_W         = 4,
    parameter int INST_W         = 8,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              ld_valid,
    input  logic [INST_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ProgramAddress,
    output logic [INST_W-1:0] instruction_data,
    output logic              cpu_rst_n,
    output logic              loading,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RELEASE,
        S_RUN
    } state_t;

`ifdef CHECKSUM_EN
    localparam state_t AFTER_LOAD = S_CHECK;
`else
    localparam state_t AFTER_LOAD = S_RELEASE;
`endif

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic [REL_W-1:0]  rel_cnt;
    logic              accept;
    logic              final_beat;
    logic              load_entry;
    logic [INST_W-1:0] mem [DEPTH];

`ifdef CHECKSUM_EN
    logic [INST_W-1:0] sum;
`endif

    assign accept     = ld_valid && ld_ready;
    assign final_beat = accept && (ld_last || wr_ptr == ADDR_W'(DEPTH - 1));
    assign load_entry = (state != S_LOAD) && (state_next == S_LOAD);

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (load_start) state_next = S_LOAD;
            S_LOAD:    if (final_beat) state_next = AFTER_LOAD;
`ifdef CHECKSUM_EN
            S_CHECK:   if (accept) state_next = (ld_data == sum) ? S_RELEASE : S_IDLE;
`endif
            S_RELEASE: if (rel_cnt == REL_W'(RELEASE_CYCLES - 1)) state_next = S_RUN;
            S_RUN:     if (load_start) state_next = S_LOAD;
            default:   state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rel_cnt   <= '0;
            ld_ready  <= 1'b0;
            loading   <= 1'b0;
            done      <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            state     <= state_next;
            ld_ready  <= (state_next == S_LOAD) || (state_next == S_CHECK);
            loading   <= (state_next == S_LOAD) || (state_next == S_CHECK);
            done      <= (state_next == S_RUN);
            cpu_rst_n <= (state_next == S_RUN);

            if (load_entry)
                wr_ptr <= '0;
            else if (state == S_LOAD && accept && !final_beat)
                wr_ptr <= wr_ptr + 1'b1;

            if (state == S_RELEASE && state_next == S_RELEASE)
                rel_cnt <= rel_cnt + 1'b1;
            else
                rel_cnt <= '0;
        end
    end

    // NOTE: the store has no reset; a program must survive a reset of the sequencer.
    always_ff @(posedge clk) begin
        if (rst_n && state == S_LOAD && accept)
            mem[wr_ptr] <= ld_data;
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum <= '0;
            err <= 1'b0;
        end else if (load_entry) begin
            sum <= '0;
            err <= 1'b0;
        end else if (state == S_LOAD && accept) begin
            sum <= sum + ld_data;
        end else if (state == S_CHECK && accept && ld_data != sum) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Fetches return zero until a complete program is in place.
    always_comb begin
        instruction_data = '0;
        if (state == S_RELEASE || state == S_RUN)
            instruction_data = mem[ProgramAddress];
    end

endmodule

// File: tb/tb_k2_program_loader.sv
// Self-checking bench for k2_program_loader: directed load/run scenarios with
// randomized beats, gaps and fetch addresses checked against a memory model.
module tb_k2_program_loader;

    localparam int ADDR_W         = 4;
    localparam int INST_W         = 8;
    localparam int RELEASE_CYCLES = 2;
    localparam int DEPTH          = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start;
    logic              ld_valid;
    logic [INST_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [ADDR_W-1:0] ProgramAddress;
    logic [INST_W-1:0] instruction_data;
    logic              cpu_rst_n;
    logic              loading;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    logic [INST_W-1:0] model_mem [DEPTH];
    bit                model_err = 1'b0;

    always #5 clk = ~clk;

    k2_program_loader #(
        .ADDR_W         (ADDR_W),
        .INST_W         (INST_W),
        .RELEASE_CYCLES (RELEASE_CYCLES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_start       (load_start),
        .ld_valid         (ld_valid),
        .ld_data          (ld_data),
        .ld_last          (ld_last),
        .ld_ready         (ld_ready),
        .ProgramAddress   (ProgramAddress),
        .instruction_data (instruction_data),
        .cpu_rst_n        (cpu_rst_n),
        .loading          (loading),
        .done             (done),
        .err              (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input bit e_ready, input bit e_loading,
                                 input bit e_done, input bit e_cpu);
        check({tag, ".ld_ready"},  32'(ld_ready),  32'(e_ready));
        check({tag, ".loading"},   32'(loading),   32'(e_loading));
        check({tag, ".done"},      32'(done),      32'(e_done));
        check({tag, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'(e_cpu));
        check({tag, ".err"},       32'(err),       32'(model_err));
    endtask

    // Random fetches: the stored program when serving, zero otherwise.
    task automatic check_fetch(input string tag, input bit serving, input int n);
        for (int k = 0; k < n; k++) begin
            ProgramAddress = ADDR_W'($urandom_range(DEPTH - 1, 0));
            #1;
            check(tag, 32'(instruction_data), serving ? 32'(model_mem[ProgramAddress]) : 32'h0);
        end
    endtask

    task automatic start_load(input string tag);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        model_err  = 1'b0;
        check_outputs(tag, 1'b1, 1'b1, 1'b0, 1'b0);
        check_fetch({tag, ".fetch"}, 1'b0, 2);
    endtask

    // valid_mode: 0 = always valid, 1 = every other cycle, 2 = random gaps.
    task automatic load_beats(input logic [INST_W-1:0] beats[$], input bit use_last,
                              input int valid_mode, input bit hold_start,
                              input bit complete, input int cks_delta);
        int                i   = 0;
        int                cyc = 0;
        int                ptr = 0;
        logic [INST_W-1:0] sum = '0;
        bit                v;
        load_start = hold_start;
        while (i < beats.size()) begin
            case (valid_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = $urandom_range(2, 0) != 0;
            endcase
            ld_valid = v;
            ld_data  = v ? beats[i] : INST_W'($urandom);
            ld_last  = v ? (use_last && i == beats.size() - 1) : 1'($urandom_range(1, 0));
            check("ld_ready_in_load", 32'(ld_ready), 32'h1);
            check("fetch_blank_in_load", 32'(instruction_data), 32'h0);
            tick();
            cyc++;
            if (v) begin
                model_mem[ptr] = beats[i];
                sum            = sum + beats[i];
                ptr++;
                i++;
            end
        end
        ld_valid   = 1'b0;
        ld_last    = 1'b0;
        load_start = 1'b0;
`ifdef CHECKSUM_EN
        if (complete) begin
            check_outputs("check_phase", 1'b1, 1'b1, 1'b0, 1'b0);
            check("fetch_blank_in_check", 32'(instruction_data), 32'h0);
            ld_valid = 1'b1;
            ld_data  = sum + INST_W'(cks_delta);
            tick();
            ld_valid = 1'b0;
            if (cks_delta != 0) model_err = 1'b1;
        end
`else
        if (complete && cks_delta != 0) model_err = 1'b0;
`endif
    endtask

    // The CPU stays in reset for RELEASE_CYCLES cycles after the final beat, then runs.
    task automatic finish_release(input string tag);
        for (int k = 0; k < RELEASE_CYCLES; k++) begin
            check_outputs({tag, ".release"}, 1'b0, 1'b0, 1'b0, 1'b0);
            check_fetch({tag, ".fetch_release"}, 1'b1, 1);
            tick();
        end
        check_outputs({tag, ".run"}, 1'b0, 1'b0, 1'b1, 1'b1);
        check_fetch({tag, ".fetch_run"}, 1'b1, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [INST_W-1:0] q[$];
        int                len;
        bit                last_flag;

        rst_n          = 1'b0;
        load_start     = 1'b0;
        ld_valid       = 1'b0;
        ld_data        = '0;
        ld_last        = 1'b0;
        ProgramAddress = '0;
        tick();
        tick();
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_fetch("reset.fetch", 1'b0, 2);
        rst_n = 1'b1;
        tick();
        tick();
        check_outputs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 1: sixteen back-to-back beats 0x10..0x1F.
        q = {};
        for (int k = 0; k < DEPTH; k++) q.push_back(INST_W'(8'h10 + k));
        start_load("t1.start");
        load_beats(q, 1'b0, 0, 1'b0, 1'b1, 0);
        finish_release("t1");
        ProgramAddress = 4'd5;
        #1;
        check("t1.addr5", 32'(instruction_data), 32'h15);
        tick();
        tick();
        check_outputs("t1.stay_run", 1'b0, 1'b0, 1'b1, 1'b1);

        // Test 2: every-other-cycle valid, load_start held (ignored) during the load.
        start_load("t2.start");
        load_beats(q, 1'b0, 1, 1'b1, 1'b1, 0);
        finish_release("t2");
        for (int a = 0; a < DEPTH; a++) begin
            ProgramAddress = ADDR_W'(a);
            #1;
            check("t2.contents", 32'(instruction_data), 32'(8'h10 + a));
        end

        // Test 3: short reload ended by ld_last keeps the tail of the old program.
        q = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
        start_load("t3.start");
        load_beats(q, 1'b1, 2, 1'b0, 1'b1, 0);
        finish_release("t3");
        ProgramAddress = 4'd3;
        #1;
        check("t3.addr3", 32'(instruction_data), 32'hA3);
        ProgramAddress = 4'd4;
        #1;
        check("t3.addr4", 32'(instruction_data), 32'h14);

        // Test 4: reloads requested from RUN with random programs and gaps.
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(DEPTH, 1);
            last_flag = (len < DEPTH) ? 1'b1 : 1'($urandom_range(1, 0));
            q = {};
            for (int k = 0; k < len; k++) q.push_back(INST_W'($urandom));
            start_load("t4.start");
            load_beats(q, last_flag, 2, 1'b0, 1'b1, 0);
            finish_release("t4");
        end

        // Test 5: reset after seven beats aborts the load but keeps what was written.
        q = {};
        for (int k = 0; k < 7; k++) q.push_back(INST_W'($urandom));
        start_load("t5.start");
        load_beats(q, 1'b0, 0, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        model_err = 1'b0;
        check_outputs("t5.reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_fetch("t5.fetch_idle", 1'b0, 2);
        tick();
        tick();
        check_outputs("t5.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        q = {8'h5A, 8'hC3};
        start_load("t5.reload");
        load_beats(q, 1'b1, 0, 1'b0, 1'b1, 0);
        finish_release("t5");
        for (int a = 0; a < DEPTH; a++) begin
            ProgramAddress = ADDR_W'(a);
            #1;
            check("t5.contents", 32'(instruction_data), 32'(model_mem[a]));
        end

`ifdef CHECKSUM_EN
        // Test 6: wrong checksum parks in IDLE with err; a correct resend runs.
        q = {};
        for (int k = 0; k < DEPTH; k++) q.push_back(8'h01);
        start_load("t6.start");
        load_beats(q, 1'b0, 0, 1'b0, 1'b1, 1);
        check_outputs("t6.bad", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6.err", 32'(err), 32'h1);
        tick();
        tick();
        check_outputs("t6.held", 1'b0, 1'b0, 1'b0, 1'b0);
        start_load("t6.resend");
        load_beats(q, 1'b0, 0, 1'b0, 1'b1, 0);
        finish_release("t6");
        check("t6.err_clear", 32'(err), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
